// File: rtl/fpa_controller.sv
// Control FSM for the 8-bit minifloat adder datapath: sequences load, add,
// normalize and result-capture stages and reports done/exception to the requester.
`timescale 1ns/1ps
module fpa_controller #(
   parameter int unsigned MAX_NORM_STEPS = 4,
   parameter int unsigned STEP_W         = 3
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [4:0] mant,
   input  logic       add_except,
   input  logic       norm_except,
   output logic       load_en,
   output logic       add_en,
   output logic       norm_en,
   output logic       norm_load,
   output logic       shift_right,
   output logic       done_en,
   output logic       busy,
   output logic       done,
   output logic       result_zero,
   output logic       except,
   output logic [1:0] exc_code
);

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StAdd,
      StCheckAdd,
      StNormLoad,
      StNormCheck,
      StNormShift,
      StDoneLoad,
      StDone,
      StExcept
   } state_e;

   localparam logic [STEP_W-1:0] StepMax = STEP_W'(MAX_NORM_STEPS);
   localparam logic [STEP_W-1:0] StepSat = {STEP_W{1'b1}};

   state_e            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              dir_q, dir_d;
   logic              rz_q, rz_d;
   logic [1:0]        code_q, code_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
         step_q  <= '0;
         dir_q   <= 1'b0;
         rz_q    <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         rz_q    <= rz_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      dir_d       = dir_q;
      rz_d        = rz_q;
      code_d      = code_q;
      load_en     = 1'b0;
      add_en      = 1'b0;
      norm_en     = 1'b0;
      norm_load   = 1'b0;
      shift_right = 1'b0;
      done_en     = 1'b0;
      done        = 1'b0;
      except      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               step_d  = '0;
               rz_d    = 1'b0;
               code_d  = 2'b00;
            end
         end
         StLoad: begin
            load_en = 1'b1;
            state_d = StAdd;
         end
         StAdd: begin
            add_en  = 1'b1;
            state_d = StCheckAdd;
         end
         StCheckAdd: begin
            if (add_except) begin
               code_d  = 2'b01;
               state_d = StExcept;
            end else begin
               state_d = StNormLoad;
            end
         end
         StNormLoad: begin
            norm_en   = 1'b1;
            norm_load = 1'b1;
            state_d   = StNormCheck;
         end
         // Checks are priority-ordered: inf/NaN, zero, normalized, step budget, direction.
         StNormCheck: begin
            if (norm_except) begin
               code_d  = 2'b10;
               state_d = StExcept;
            end else if (mant == 5'b00000) begin
               rz_d    = 1'b1;
               state_d = StDoneLoad;
            end else if (mant[4:3] == 2'b01) begin
               state_d = StDoneLoad;
            end else if (step_q == StepMax) begin
               code_d  = 2'b11;
               state_d = StExcept;
            end else begin
               dir_d   = mant[4];
               state_d = StNormShift;
            end
         end
         StNormShift: begin
            norm_en     = 1'b1;
            shift_right = dir_q;
            if (step_q != StepSat) begin
               step_d = step_q + STEP_W'(1);
            end
            state_d = StNormCheck;
         end
         StDoneLoad: begin
            done_en = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         StExcept: begin
            except  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy        = (state_q != StIdle);
   assign result_zero = rz_q;
   assign exc_code    = code_q;

endmodule

// File: tb/tb_fpa_controller.sv
// Scoreboard bench for fpa_controller: a driver pushes expected completions,
// a negedge monitor pops and compares them against done/except events.
`timescale 1ns/1ps
module tb_fpa_controller;

   logic       clk = 1'b0;
   logic       clr;
   logic       start;
   logic [4:0] mant;
   logic       add_except;
   logic       norm_except;
   logic       load_en, add_en, norm_en, norm_load, shift_right, done_en;
   logic       busy, done, result_zero, except;
   logic [1:0] exc_code;

   fpa_controller #(.MAX_NORM_STEPS(4), .STEP_W(3)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .mant        (mant),
      .add_except  (add_except),
      .norm_except (norm_except),
      .load_en     (load_en),
      .add_en      (add_en),
      .norm_en     (norm_en),
      .norm_load   (norm_load),
      .shift_right (shift_right),
      .done_en     (done_en),
      .busy        (busy),
      .done        (done),
      .result_zero (result_zero),
      .except      (except),
      .exc_code    (exc_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Datapath model: mantissa sequence advances on every shift of the normalize register.
   logic [4:0] mant_seq [8];
   logic [2:0] mant_idx;
   always @(posedge clk or negedge clr) begin
      if (!clr) mant_idx <= 3'd0;
      else if (start && !busy) mant_idx <= 3'd0;
      else if (norm_en && !norm_load && mant_idx < 3'd7) mant_idx <= mant_idx + 3'd1;
   end
   assign mant = mant_seq[mant_idx];

   typedef struct {
      int         is_exc;
      int         base;
      int         lat;
      int         rz;
      int         code;
      int         n_right;
      int         n_left;
      int         has_norm;
      int         n_den;
   } exp_t;
   exp_t sb[$];

   int ld_c, add_c, nl_c, den_c, den_n, nr, nlf, bad_sr;
   int ev_cnt = 0;

   task automatic clear_op();
      ld_c = -1; add_c = -1; nl_c = -1; den_c = -1;
      den_n = 0; nr = 0; nlf = 0; bad_sr = 0;
   endtask

   initial clear_op();

   always @(negedge clk) begin
      exp_t e;
      if (!clr) begin
         clear_op();
      end else begin
         if (load_en && ld_c < 0) ld_c = cyc;
         if (add_en && add_c < 0) add_c = cyc;
         if (norm_en && norm_load && nl_c < 0) nl_c = cyc;
         if (done_en) begin den_n++; den_c = cyc; end
         if (shift_right && !(norm_en && !norm_load)) bad_sr = 1;
         if (norm_en && !norm_load) begin
            if (shift_right) nr++;
            else nlf++;
         end
         if (done || except) begin
            ev_cnt++;
            check("event_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("kind_except", int'(except), e.is_exc);
               check("kind_done", int'(done), 1 - e.is_exc);
               check("latency", cyc - e.base, e.lat);
               check("result_zero", int'(result_zero), e.rz);
               check("exc_code", int'(exc_code), e.code);
               check("load_en_cycle", (ld_c < 0) ? -1 : ld_c - e.base, 1);
               check("add_en_cycle", (add_c < 0) ? -1 : add_c - e.base, 2);
               check("norm_load_cycle", (nl_c < 0) ? -1 : nl_c - e.base, e.has_norm ? 4 : -1);
               check("done_en_count", den_n, e.n_den);
               check("done_en_cycle", (den_c < 0) ? -1 : den_c - e.base,
                     (e.n_den > 0) ? e.lat - 1 : -1);
               check("right_shifts", nr, e.n_right);
               check("left_shifts", nlf, e.n_left);
               check("shift_right_outside_shift", bad_sr, 0);
            end
            clear_op();
         end
      end
   end

   function automatic logic [39:0] pk(input logic [4:0] a, b, c, d);
      return {d, d, d, d, d, c, b, a};
   endfunction

   function automatic int outs_vec();
      return int'({load_en, add_en, norm_en, norm_load, shift_right, done_en,
                   busy, done, result_zero, except, exc_code});
   endfunction

   task automatic run_op(input string name, input logic [39:0] seq, input logic aex,
                         input logic nex, input int is_exc, input int lat, input int rz,
                         input int code, input int n_right, input int n_left,
                         input int has_norm, input int hold);
      exp_t e;
      int   ev0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) mant_seq[i] = seq[i*5 +: 5];
      add_except  = aex;
      norm_except = nex;
      e.is_exc = is_exc; e.base = cyc; e.lat = lat; e.rz = rz; e.code = code;
      e.n_right = n_right; e.n_left = n_left; e.has_norm = has_norm;
      e.n_den = is_exc ? 0 : 1;
      ev0 = ev_cnt;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      check({name, "_busy"}, int'(busy), 1);
      repeat (hold - 1) @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check({name, "_completed"}, sb.size(), 0);
      sb.delete();
      @(negedge clk);
      check({name, "_idle"}, int'(busy), 0);
      check({name, "_rz_hold"}, int'(result_zero), rz);
      check({name, "_code_hold"}, int'(exc_code), code);
      check({name, "_event_count"}, ev_cnt - ev0, 1);
      add_except  = 1'b0;
      norm_except = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int ev0;
      int seen;
      clr = 1'b0; start = 1'b0; add_except = 1'b0; norm_except = 1'b0;
      for (int i = 0; i < 8; i++) mant_seq[i] = 5'b01000;
      repeat (2) @(negedge clk);
      check("reset_outputs", outs_vec(), 0);
      clr = 1'b1;
      @(negedge clk);
      check("idle_outputs", outs_vec(), 0);

      //      name       seq                                        aex   nex  exc lat rz cd  R  L  nrm hold
      run_op("noshift",  pk(5'b01010, 5'b01010, 5'b01010, 5'b01010), 1'b0, 1'b0, 0, 7,  0, 0, 0, 0, 1, 1);
      run_op("right",    pk(5'b10110, 5'b01011, 5'b01011, 5'b01011), 1'b0, 1'b0, 0, 9,  0, 0, 1, 0, 1, 1);
      run_op("left1",    pk(5'b00101, 5'b01010, 5'b01010, 5'b01010), 1'b0, 1'b0, 0, 9,  0, 0, 0, 1, 1, 1);
      run_op("left3",    pk(5'b00001, 5'b00010, 5'b00100, 5'b01000), 1'b0, 1'b0, 0, 13, 0, 0, 0, 3, 1, 1);
      run_op("zero",     pk(5'b00000, 5'b00000, 5'b00000, 5'b00000), 1'b0, 1'b0, 0, 7,  1, 0, 0, 0, 1, 1);
      run_op("add_exc",  pk(5'b01010, 5'b01010, 5'b01010, 5'b01010), 1'b1, 1'b0, 1, 4,  0, 1, 0, 0, 0, 1);
      run_op("norm_exc", pk(5'b01010, 5'b01010, 5'b01010, 5'b01010), 1'b0, 1'b1, 1, 6,  0, 2, 0, 0, 1, 1);
      run_op("step_ovf", pk(5'b00001, 5'b00001, 5'b00001, 5'b00001), 1'b0, 1'b0, 1, 14, 0, 3, 0, 4, 1, 1);
      // start held through the whole operation, including the DONE cycle
      run_op("busy_start", pk(5'b01010, 5'b01010, 5'b01010, 5'b01010), 1'b0, 1'b0, 0, 7, 0, 0, 0, 0, 1, 8);
      run_op("after_exc", pk(5'b10110, 5'b01011, 5'b01011, 5'b01011), 1'b0, 1'b0, 0, 9, 0, 0, 1, 0, 1, 1);

      // Reset asserted in the middle of a normalize shift.
      for (int i = 0; i < 8; i++) mant_seq[i] = 5'b00001;
      ev0 = ev_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (norm_en && !norm_load) seen = 1;
      end
      check("abort_reached_shift", seen, 1);
      #2 clr = 1'b0;
      #1 check("abort_outputs_zero", outs_vec(), 0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_no_event", ev_cnt - ev0, 0);
      check("abort_idle", outs_vec(), 0);

      run_op("post_abort", pk(5'b01010, 5'b01010, 5'b01010, 5'b01010), 1'b0, 1'b0, 0, 7, 0, 0, 0, 0, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpa_controller.md
Name: fpa_controller

Overview:
Control FSM for the 8-bit minifloat adder datapath (1 sign, 4 exp, 3 mant bits). It sequences the datapath register enables and mux selects through the stages LOAD -> ADD -> NORMALIZE -> DONE. It consumes the datapath status (mantissa and exception flags) and reports completion or exception to the external requester through a start/done handshake.

Parameters:
MAX_NORM_STEPS, 4, maximum normalize shifts per operation before a step-overflow exception.
STEP_W, 3, step counter width; must hold 0..MAX_NORM_STEPS.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous active-low reset.
start  input  1  request an add; sampled only in IDLE.
mant  input  5  normalize-register mantissa (format 01.xxx when normalized); valid in NORM_CHECK.
add_except  input  1  add-stage exception; valid in CHECK_ADD.
norm_except  input  1  exponent all-ones (inf/NaN); valid in NORM_CHECK.
load_en  output  1  operand register enable.
add_en  output  1  add register enable.
norm_en  output  1  normalize register enable.
norm_load  output  1  normalize mux select: 1 = load from the add stage, 0 = shift.
shift_right  output  1  shift direction: 1 = right with exp+1, 0 = left with exp-1.
done_en  output  1  result register enable.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse: result valid.
result_zero  output  1  qualifies done: result mantissa was zero.
except  output  1  one-cycle pulse: operation aborted.
exc_code  output  2  qualifies except: 01 add exception, 10 inf/NaN, 11 step overflow.

Behaviour:
- Reset (clr low, asynchronous):
  - state = IDLE; step counter = 0; direction register = 0; result_zero = 0; exc_code = 00.
  - All other outputs are 0.
  - Asserting reset mid-operation aborts immediately. No done or except pulse is produced.
- Outputs are Moore-decoded from state and registered flags. Enables not listed for a state are 0.
- IDLE:
  - start = 1 -> LOAD.
  - On leaving IDLE, clear the step counter, result_zero, and exc_code.
- LOAD: load_en = 1 -> ADD.
- ADD: add_en = 1 -> CHECK_ADD.
- CHECK_ADD:
  - add_except = 1 -> EXCEPT with code 01.
  - Otherwise -> NORM_LOAD.
- NORM_LOAD: norm_en = 1, norm_load = 1 -> NORM_CHECK.
- NORM_CHECK (no enables asserted); evaluate in priority order:
  1. norm_except = 1 -> EXCEPT, code 10.
  2. mant == 0 -> set result_zero -> DONE_LOAD.
  3. mant[4:3] == 01 -> DONE_LOAD.
  4. step counter == MAX_NORM_STEPS -> EXCEPT, code 11.
  5. mant[4] == 1 -> direction register = 1 -> NORM_SHIFT.
  6. Otherwise (mant[4:3] == 00, nonzero) -> direction register = 0 -> NORM_SHIFT.
- NORM_SHIFT:
  - norm_en = 1, norm_load = 0, shift_right = direction register.
  - Step counter increments by 1 (saturating) -> NORM_CHECK.
- DONE_LOAD: done_en = 1 -> DONE.
- DONE: done = 1 for one cycle -> IDLE.
- EXCEPT: except = 1 for one cycle; exc_code holds the code -> IDLE. done_en is never asserted on the exception path.
- start while busy = 1 is ignored; no queuing. start in a DONE or EXCEPT cycle is also ignored; the requester re-asserts start in IDLE.
- result_zero and exc_code hold their values until the next accepted start.
- Latency: start sampled at edge 0.
  - Path with no shifts: done is high during cycle 7.
  - Each normalize shift adds 2 cycles.
  - add_except path: except is high during cycle 4.
- shift_right = 0 in every state other than NORM_SHIFT.

Test Plan:
- No shift: start pulse; mant = 01010 at NORM_CHECK.
  - load_en, add_en, norm_en+norm_load, done_en each pulse once, in order.
  - done = 1 at cycle 7; result_zero = 0.
- Right shift: mant = 10110, then 01011.
  - One NORM_SHIFT with shift_right = 1.
  - done at cycle 9.
- Left shifts: mant = 00101 -> 01010.
  - One shift, shift_right = 0, done at cycle 9.
  - Repeat with mant 00001 -> 00010 -> 00100 -> 01000: three shifts, done at cycle 13.
- Zero and exceptions:
  - mant = 00000 -> done at cycle 7 with result_zero = 1.
  - add_except = 1 in CHECK_ADD -> except at cycle 4, exc_code = 01, done_en never asserted.
  - norm_except = 1 -> exc_code = 10.
- Step overflow: mant held at 00001 for every check.
  - 4 shifts occur, then except with exc_code = 11.
- Reset and start handling:
  - clr low during NORM_SHIFT -> all outputs 0 immediately; no done or except pulse.
  - start pulses while busy -> exactly one done is produced.
